// File: rtl/fetch_queue.sv
// fetch_queue: line fetch from the instruction cache into a halfword circular buffer.
// Optional statistics counters are built when FETCHQ_STATS_EN is defined.
module fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] cache_data,
    input  logic        cache_wt,
    output logic [31:0] fetch_addr,
    output logic [15:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] miss_count,
    output logic [31:0] stall_cycles
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH - 4);

    typedef enum logic [1:0] {
        S_STREAM,
        S_STALL,
        S_FULL
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [31:0]     r_fetch_pc;
    logic [15:0]     r_mem_instr [DEPTH];
    logic [31:0]     r_mem_pc    [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;
    logic [1:0]      w_off;
    logic [2:0]      w_nenq;
    logic            w_accept;
    logic            w_pop;

    always_comb begin
        w_state_nx = S_STREAM;
        if (cache_wt) begin
            w_state_nx = S_STALL;
        end else if (r_count > LIM) begin
            w_state_nx = S_FULL;
        end
    end

    assign w_off       = r_fetch_pc[1:0];
    assign w_nenq      = 3'd4 - {1'b0, w_off};
    assign w_accept    = ~redirect & (w_state_nx == S_STREAM);
    assign instr_valid = (r_count != '0);
    assign w_pop       = instr_valid & instr_ready;

    assign fetch_addr  = {r_fetch_pc[31:2], 2'b00};
    assign instr       = instr_valid ? r_mem_instr[r_head] : 16'h0;
    assign instr_pc    = instr_valid ? r_mem_pc[r_head] : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_STALL;
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nx;
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= {r_fetch_pc[31:2] + 30'd1, 2'b00};
                    r_tail     <= r_tail + AW'(w_nenq);
                end
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                r_count <= r_count
                         + (w_accept ? (AW+1)'(w_nenq) : '0)
                         - (w_pop ? (AW+1)'(1) : '0);
            end
        end
    end

    // Halfwords below the entry offset belong to the previous path.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_accept && (2'(k) >= w_off)) begin
                r_mem_instr[r_tail + AW'(k) - AW'(w_off)] <= cache_data[16*k +: 16];
                r_mem_pc[r_tail + AW'(k) - AW'(w_off)]    <= {r_fetch_pc[31:2], 2'(k)};
            end
        end
    end

`ifdef FETCHQ_STATS_EN
    logic [31:0] r_miss;
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_miss  <= '0;
            r_stall <= '0;
        end else begin
            if (cache_wt) begin
                r_stall <= r_stall + 32'd1;
            end
            if (cache_wt && (r_state != S_STALL)) begin
                r_miss <= r_miss + 32'd1;
            end
        end
    end

    assign miss_count   = r_miss;
    assign stall_cycles = r_stall;
`else
    logic w_unused_state;
    assign w_unused_state = (r_state == S_STALL);
    assign miss_count     = 32'h0;
    assign stall_cycles   = 32'h0;
`endif

endmodule
